cacheline_adapter: RTL and testbench

Memory-side responder for the data-cache fill/writeback port (the `dfp_*` interface). It accepts one 256-bit line read or write per transaction from the cache and converts it into a 4-beat, 64-bit burst on the banked memory (`bmem_*`) interface. It then returns a single-cycle `dfp_resp`. It sits between the dcache and the burst memory model or controller, one instance per cache.

---
 rtl/rv32i_types.sv | 7 +
 rtl/line_beat_buf.sv | 33 +++
 rtl/cacheline_adapter.sv | 80 ++++++++
 tb/tb_cacheline_adapter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: shared line/beat constants and adapter FSM state type
package rv32i_types;
  localparam int LINE_BITS = 256;
  localparam int BEAT_BITS = 64;
  localparam int BEATS = 4;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP} adapter_state_t;
endpackage

// File: rtl/line_beat_buf.sv
// line_beat_buf: 256-bit line register with 2-bit beat counter, beat insert/select and last-beat flag
// ports: clk, rst_n (sync, active-low), clear (zero counter), load/load_line (latch whole line),
//        step (advance counter), ins/beat_in (store beat k), line, beat_out (beat k), last (k==3)
module line_beat_buf
  import rv32i_types::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 load,
  input  logic [LINE_BITS-1:0] load_line,
  input  logic                 step,
  input  logic                 ins,
  input  logic [BEAT_BITS-1:0] beat_in,
  output logic [LINE_BITS-1:0] line,
  output logic [BEAT_BITS-1:0] beat_out,
  output logic                 last
);
  logic [1:0] k;
  assign beat_out = line[{k, 6'd0} +: BEAT_BITS];
  assign last = k == 2'(BEATS - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line <= '0;
      k <= '0;
    end else begin
      if (load) line <= load_line;
      else if (ins) line[{k, 6'd0} +: BEAT_BITS] <= beat_in;
      if (clear) k <= '0;
      else if (step) k <= k + 2'd1;
    end
  end
endmodule

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: converts 256-bit dfp line read/write into a 4-beat 64-bit bmem burst
// ports: clk, rst_n (sync, active-low); dfp_addr/read/write/wdata in, dfp_rdata/resp out;
//        bmem_addr/read/write/wdata out, bmem_ready/raddr/rdata/rvalid in
// config: POSTED_WRITE_EN responds to writes right after latching and drains the burst in the background
module cacheline_adapter
  import rv32i_types::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          dfp_addr,
  input  logic                 dfp_read,
  input  logic                 dfp_write,
  input  logic [LINE_BITS-1:0] dfp_wdata,
  output logic [LINE_BITS-1:0] dfp_rdata,
  output logic                 dfp_resp,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [31:0]          bmem_raddr,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid
);
`ifdef POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif
  adapter_state_t state, next;
  logic [31:0] addr_q;
  logic [LINE_BITS-1:0] rdata_q, line;
  logic start, load, ins, step, last, resp_q, unused_in;
  assign unused_in = ^{dfp_addr[4:0], bmem_raddr};
  assign start = state == IDLE && (dfp_read || dfp_write);
  assign load = state == IDLE && dfp_write;
  assign ins = state == RD_WAIT && bmem_rvalid;
  assign step = ins || (state == WR_BURST && bmem_ready);
  assign bmem_addr = addr_q;
  assign bmem_read = state == RD_REQ;
  assign bmem_write = state == WR_BURST;
  assign dfp_rdata = rdata_q;
  assign dfp_resp = state == RESP || resp_q;
  line_beat_buf u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .clear(start),
    .load(load),
    .load_line(dfp_wdata),
    .step(step),
    .ins(ins),
    .beat_in(bmem_rdata),
    .line(line),
    .beat_out(bmem_wdata),
    .last(last)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = dfp_write ? WR_BURST : dfp_read ? RD_REQ : IDLE;
      RD_REQ:   next = bmem_ready ? RD_WAIT : RD_REQ;
      RD_WAIT:  next = ins && last ? RESP : RD_WAIT;
      WR_BURST: next = step && last ? (POSTED ? IDLE : RESP) : WR_BURST;
      default:  next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      addr_q <= '0;
      rdata_q <= '0;
      resp_q <= 1'b0;
    end else begin
      state <= next;
      resp_q <= POSTED && load;
      if (start) addr_q <= {dfp_addr[31:5], 5'b0};
      if (ins && last) rdata_q <= {bmem_rdata, line[LINE_BITS-BEAT_BITS-1:0]};
    end
  end
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: directed self-checking bench for cacheline_adapter
module tb_cacheline_adapter;
`ifdef POSTED_WRITE_EN
  localparam int WR_STALL_RESP = 1, WR_RESP = 1, B2B_RD_CYC = 6, B2B_RESP2 = 11;
`else
  localparam int WR_STALL_RESP = 8, WR_RESP = 5, B2B_RD_CYC = 7, B2B_RESP2 = 12;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] dfp_addr;
  logic dfp_read, dfp_write;
  logic [255:0] dfp_wdata, dfp_rdata;
  logic dfp_resp;
  logic [31:0] bmem_addr;
  logic bmem_read, bmem_write;
  logic [63:0] bmem_wdata;
  logic bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic bmem_rvalid;
  int checks = 0, errors = 0, cyc = 0;
  logic [255:0] held_line;
  always #5 clk = ~clk;
  cacheline_adapter dut (
    .clk(clk),
    .rst_n(rst_n),
    .dfp_addr(dfp_addr),
    .dfp_read(dfp_read),
    .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata),
    .dfp_rdata(dfp_rdata),
    .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr),
    .bmem_read(bmem_read),
    .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata),
    .bmem_ready(bmem_ready),
    .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    dfp_addr = '0;
    dfp_read = 1'b0;
    dfp_write = 1'b0;
    dfp_wdata = '0;
    bmem_ready = 1'b1;
    bmem_raddr = '0;
    bmem_rdata = '0;
    bmem_rvalid = 1'b0;
    tick();
    tick();
    checks++;
    if ({dfp_resp, bmem_read, bmem_write} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000", {dfp_resp, bmem_read, bmem_write});
    end
    checks++;
    if (bmem_addr !== 32'h0 || bmem_wdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_bmem: got addr %h wdata %h expected 0 0", bmem_addr, bmem_wdata);
    end
    checks++;
    if (dfp_rdata !== 256'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 0", dfp_rdata);
    end
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_read;
    logic [63:0] b[4];
    b = '{{8{8'h11}}, {8{8'h22}}, {8{8'h33}}, {8{8'h44}}};
    dfp_addr = 32'h0000_1234;
    dfp_read = 1'b1;
    cyc = 0;
    tick();
    checks++;
    if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_1220) begin
      errors++;
      $display("FAIL read_cmd: got read %b addr %h expected 1 00001220", bmem_read, bmem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      bmem_rvalid = 1'b1;
      bmem_rdata = b[i];
    end
    checks++;
    if (dfp_resp !== 1'b0) begin
      errors++;
      $display("FAIL read_early_resp: got %b expected 0 in cycle 5", dfp_resp);
    end
    tick();
    bmem_rvalid = 1'b0;
    checks++;
    if (dfp_resp !== 1'b1) begin
      errors++;
      $display("FAIL read_resp: got %b expected 1 in cycle 6", dfp_resp);
    end
    checks++;
    if (dfp_rdata !== {b[3], b[2], b[1], b[0]}) begin
      errors++;
      $display("FAIL read_data: got %h expected %h", dfp_rdata, {b[3], b[2], b[1], b[0]});
    end
    held_line = {b[3], b[2], b[1], b[0]};
    tick();
    dfp_read = 1'b0;
    checks++;
    if (dfp_resp !== 1'b0) begin
      errors++;
      $display("FAIL read_resp_width: got %b expected 0 in cycle 7", dfp_resp);
    end
    tick();
    checks++;
    if (bmem_read !== 1'b0) begin
      errors++;
      $display("FAIL read_no_reserve: got %b expected 0", bmem_read);
    end
  endtask
  task automatic test_write_stall;
    logic [63:0] b[4];
    logic [63:0] acc[4];
    int n, held, resp_cyc, nresp;
    logic drop, addr_ok;
    b = '{{8{8'hA0}}, {8{8'hA1}}, {8{8'hA2}}, {8{8'hA3}}};
    acc = '{64'h0, 64'h0, 64'h0, 64'h0};
    n = 0;
    held = 0;
    resp_cyc = -1;
    nresp = 0;
    drop = 1'b0;
    addr_ok = 1'b1;
    dfp_addr = 32'h0000_205F;
    dfp_wdata = {b[3], b[2], b[1], b[0]};
    dfp_write = 1'b1;
    cyc = 0;
    repeat (12) begin
      tick();
      if (drop) dfp_write = 1'b0;
      drop = dfp_resp;
      if (dfp_resp) begin
        nresp++;
        if (resp_cyc < 0) resp_cyc = cyc;
      end
      bmem_ready = !(cyc >= 2 && cyc <= 4);
      if (bmem_write && bmem_wdata === b[1]) held++;
      if (bmem_write && bmem_ready) begin
        if (n < 4) acc[n] = bmem_wdata;
        n++;
        if (bmem_addr !== 32'h0000_2040) addr_ok = 1'b0;
      end
    end
    bmem_ready = 1'b1;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL wr_beat_count: got %0d expected 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (acc[i] !== b[i]) begin
        errors++;
        $display("FAIL wr_beat%0d: got %h expected %h", i, acc[i], b[i]);
      end
    end
    checks++;
    if (held !== 4) begin
      errors++;
      $display("FAIL wr_beat1_hold: got %0d cycles expected 4", held);
    end
    checks++;
    if (resp_cyc !== WR_STALL_RESP || nresp !== 1) begin
      errors++;
      $display("FAIL wr_resp: got cycle %0d count %0d expected cycle %0d count 1", resp_cyc, nresp, WR_STALL_RESP);
    end
    checks++;
    if (!addr_ok) begin
      errors++;
      $display("FAIL wr_addr: got misaligned bmem_addr expected 00002040");
    end
    checks++;
    if (dfp_rdata !== held_line) begin
      errors++;
      $display("FAIL wr_keeps_rdata: got %h expected %h", dfp_rdata, held_line);
    end
  endtask
  task automatic test_back_to_back;
    logic [63:0] d[4];
    logic [255:0] rd_line;
    logic [31:0] rd_addr;
    int phase, left, nresp, wbeats, rd_cyc, resp2;
    logic drop;
    d = '{{8{8'hD0}}, {8{8'hD1}}, {8{8'hD2}}, {8{8'hD3}}};
    phase = 0;
    left = 0;
    nresp = 0;
    wbeats = 0;
    rd_cyc = -1;
    resp2 = -1;
    rd_addr = '0;
    rd_line = '0;
    drop = 1'b0;
    dfp_addr = 32'h0000_3000;
    dfp_wdata = {{8{8'hC3}}, {8{8'hC2}}, {8{8'hC1}}, {8{8'hC0}}};
    dfp_write = 1'b1;
    cyc = 0;
    repeat (20) begin
      tick();
      if (drop) begin
        if (phase == 0) begin
          dfp_write = 1'b0;
          dfp_read = 1'b1;
          dfp_addr = 32'h0000_4000;
        end else dfp_read = 1'b0;
        phase++;
      end
      drop = dfp_resp;
      if (dfp_resp) begin
        nresp++;
        if (nresp == 2) begin
          resp2 = cyc;
          rd_line = dfp_rdata;
        end
      end
      if (bmem_write && bmem_ready) wbeats++;
      if (left > 0) begin
        bmem_rvalid = 1'b1;
        bmem_rdata = d[4-left];
        left--;
      end else bmem_rvalid = 1'b0;
      if (bmem_read && rd_cyc < 0) begin
        rd_cyc = cyc;
        rd_addr = bmem_addr;
        left = 4;
      end
    end
    bmem_rvalid = 1'b0;
    checks++;
    if (nresp !== 2) begin
      errors++;
      $display("FAIL b2b_resp_count: got %0d expected 2", nresp);
    end
    checks++;
    if (wbeats !== 4) begin
      errors++;
      $display("FAIL b2b_wr_beats: got %0d expected 4", wbeats);
    end
    checks++;
    if (rd_cyc !== B2B_RD_CYC || rd_addr !== 32'h0000_4000) begin
      errors++;
      $display("FAIL b2b_rd_cmd: got cycle %0d addr %h expected cycle %0d addr 00004000", rd_cyc, rd_addr, B2B_RD_CYC);
    end
    checks++;
    if (resp2 !== B2B_RESP2) begin
      errors++;
      $display("FAIL b2b_rd_resp: got cycle %0d expected %0d", resp2, B2B_RESP2);
    end
    checks++;
    if (rd_line !== {d[3], d[2], d[1], d[0]}) begin
      errors++;
      $display("FAIL b2b_rd_data: got %h expected %h", rd_line, {d[3], d[2], d[1], d[0]});
    end
    held_line = {d[3], d[2], d[1], d[0]};
  endtask
  task automatic test_both_stray;
    int nresp, rds, wbeats, resp_cyc;
    logic drop;
    bmem_rvalid = 1'b1;
    bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (3) tick();
    checks++;
    if (dfp_rdata !== held_line) begin
      errors++;
      $display("FAIL stray_idle: got %h expected %h", dfp_rdata, held_line);
    end
    nresp = 0;
    rds = 0;
    wbeats = 0;
    resp_cyc = -1;
    drop = 1'b0;
    dfp_addr = 32'h0000_5000;
    dfp_wdata = {{8{8'hE3}}, {8{8'hE2}}, {8{8'hE1}}, {8{8'hE0}}};
    dfp_read = 1'b1;
    dfp_write = 1'b1;
    cyc = 0;
    repeat (12) begin
      tick();
      if (drop) begin
        dfp_read = 1'b0;
        dfp_write = 1'b0;
      end
      drop = dfp_resp;
      if (dfp_resp) begin
        nresp++;
        if (resp_cyc < 0) resp_cyc = cyc;
      end
      if (bmem_read) rds++;
      if (bmem_write && bmem_ready) wbeats++;
    end
    bmem_rvalid = 1'b0;
    checks++;
    if (rds !== 0 || wbeats !== 4) begin
      errors++;
      $display("FAIL both_write_wins: got reads %0d wbeats %0d expected 0 4", rds, wbeats);
    end
    checks++;
    if (nresp !== 1 || resp_cyc !== WR_RESP) begin
      errors++;
      $display("FAIL both_resp: got count %0d cycle %0d expected 1 %0d", nresp, resp_cyc, WR_RESP);
    end
    checks++;
    if (dfp_rdata !== held_line) begin
      errors++;
      $display("FAIL stray_burst: got %h expected %h", dfp_rdata, held_line);
    end
  endtask
  task automatic test_reset_mid_read;
    logic [63:0] f[4];
    logic [255:0] rd_line;
    logic [31:0] rd_addr;
    int left, nresp, rd_cyc, resp_cyc;
    logic drop;
    f = '{{8{8'hF0}}, {8{8'hF1}}, {8{8'hF2}}, {8{8'hF3}}};
    dfp_addr = 32'h0000_6000;
    dfp_read = 1'b1;
    cyc = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      bmem_rvalid = 1'b1;
      bmem_rdata = {8{8'h5A}} ^ 64'(i);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({dfp_resp, bmem_read, bmem_write} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_ctrl: got %b expected 000", {dfp_resp, bmem_read, bmem_write});
    end
    checks++;
    if (bmem_addr !== 32'h0 || bmem_wdata !== 64'h0 || dfp_rdata !== 256'h0) begin
      errors++;
      $display("FAIL midrst_data: got addr %h wdata %h rdata %h expected all 0", bmem_addr, bmem_wdata, dfp_rdata);
    end
    rst_n = 1'b1;
    dfp_addr = 32'h0000_7000;
    bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    left = 0;
    nresp = 0;
    rd_cyc = -1;
    resp_cyc = -1;
    rd_addr = '0;
    rd_line = '0;
    drop = 1'b0;
    cyc = 0;
    repeat (12) begin
      tick();
      if (drop) dfp_read = 1'b0;
      drop = dfp_resp;
      if (dfp_resp) begin
        nresp++;
        if (resp_cyc < 0) begin
          resp_cyc = cyc;
          rd_line = dfp_rdata;
        end
      end
      if (left > 0) begin
        bmem_rvalid = 1'b1;
        bmem_rdata = f[4-left];
        left--;
      end else bmem_rvalid = 1'b0;
      if (bmem_read && rd_cyc < 0) begin
        rd_cyc = cyc;
        rd_addr = bmem_addr;
        left = 4;
      end
    end
    bmem_rvalid = 1'b0;
    checks++;
    if (rd_cyc !== 1 || rd_addr !== 32'h0000_7000) begin
      errors++;
      $display("FAIL postrst_cmd: got cycle %0d addr %h expected 1 00007000", rd_cyc, rd_addr);
    end
    checks++;
    if (nresp !== 1 || resp_cyc !== 6) begin
      errors++;
      $display("FAIL postrst_resp: got count %0d cycle %0d expected 1 6", nresp, resp_cyc);
    end
    checks++;
    if (rd_line !== {f[3], f[2], f[1], f[0]}) begin
      errors++;
      $display("FAIL postrst_data: got %h expected %h", rd_line, {f[3], f[2], f[1], f[0]});
    end
  endtask
  initial begin
    test_reset();
    test_read();
    test_write_stall();
    test_back_to_back();
    test_both_stray();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
